// File: rtl/uart_tx.sv
// Ready/valid byte stream to asynchronous serial frames: start, LSB-first data,
// optional parity, one or two stop bits. Every output is a flop.
module uart_tx #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_MODE  = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                  i_clock,
   input  logic                  i_nreset,
   output logic                  o_write_ready,
   input  logic                  i_write_valid,
   input  logic [DATA_WIDTH-1:0] i_write_data,
   output logic                  o_tx,
   output logic                  o_busy
);

   // state    | meaning
   // S_IDLE   | line high, waiting for a word
   // S_START  | start bit, line low
   // S_DATA   | data bits, LSB first from shift register bit 0
   // S_PARITY | parity bit (only when PARITY_MODE != 0)
   // S_STOP   | stop bit(s), line high; may chain straight into S_START

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
   localparam logic              ODD_PAR   = (PARITY_MODE == 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                state_q, state_d;
   logic [BAUD_W-1:0]     baud_q, baud_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  par_q, par_d;
   logic                  tx_q, tx_d;
   logic                  busy_q, busy_d;
   logic                  ready_q, ready_d;
   logic                  bit_end;
   logic                  xfer;

   always_ff @(posedge i_clock or negedge i_nreset) begin
      if (!i_nreset) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
      end
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      bit_end = (baud_q == BAUD_LAST);
      xfer    = ready_q & i_write_valid;

      if (state_q != S_IDLE) begin
         baud_d = bit_end ? '0 : baud_q + 1'b1;
      end

      case (state_q)
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               bit_d   = '0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_q == DATA_LAST) begin
                  bit_d   = '0;
                  state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               bit_d   = '0;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (bit_q == STOP_LAST) begin
                  state_d = S_IDLE;
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         default: ;
      endcase

      // Ready is only ever high in IDLE or the final stop cycle, so a transfer
      // here covers both the idle start and the back-to-back chain.
      if (xfer) begin
         state_d = S_START;
         baud_d  = '0;
         bit_d   = '0;
         shift_d = i_write_data;
         par_d   = (^i_write_data) ^ ODD_PAR;
      end

      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
         S_PARITY: tx_d = par_d;
         default:  tx_d = 1'b1;
      endcase

      busy_d  = (state_d != S_IDLE);
      ready_d = (state_d == S_IDLE) ||
                ((state_d == S_STOP) && (bit_d == STOP_LAST) && (baud_d == BAUD_LAST));
   end

   assign o_tx          = tx_q;
   assign o_busy        = busy_q;
   assign o_write_ready = ready_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (plain, even parity, odd parity, two stop
// bits) checked cycle by cycle against a queue of expected line states.
module tb_uart_tx;

   localparam int CPB = 4;
   localparam int PM [4] = '{0, 1, 2, 0};
   localparam int NS [4] = '{1, 1, 1, 2};

   typedef struct {
      logic tx;
      logic busy;
      logic ready;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] valid_w = '0;
   logic [3:0] tx_w;
   logic [3:0] busy_w;
   logic [3:0] ready_w;
   logic [7:0] data = '0;
   int         sel = 0;
   int         n_checks = 0;
   int         n_pass = 0;
   exp_t       exp_q[$];
   exp_t       cur;

   always #5 clk = ~clk;

   uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(0), .STOP_BITS(1)) u_plain (
      .i_clock(clk), .i_nreset(rst_n), .o_write_ready(ready_w[0]), .i_write_valid(valid_w[0]),
      .i_write_data(data), .o_tx(tx_w[0]), .o_busy(busy_w[0]));
   uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(1), .STOP_BITS(1)) u_even (
      .i_clock(clk), .i_nreset(rst_n), .o_write_ready(ready_w[1]), .i_write_valid(valid_w[1]),
      .i_write_data(data), .o_tx(tx_w[1]), .o_busy(busy_w[1]));
   uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(2), .STOP_BITS(1)) u_odd (
      .i_clock(clk), .i_nreset(rst_n), .o_write_ready(ready_w[2]), .i_write_valid(valid_w[2]),
      .i_write_data(data), .o_tx(tx_w[2]), .o_busy(busy_w[2]));
   uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(0), .STOP_BITS(2)) u_stop2 (
      .i_clock(clk), .i_nreset(rst_n), .o_write_ready(ready_w[3]), .i_write_valid(valid_w[3]),
      .i_write_data(data), .o_tx(tx_w[3]), .o_busy(busy_w[3]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Scoreboard: one entry per clock cycle of the expected frame.
   task automatic push_frame(input int idx, input logic [7:0] d);
      logic bits[$];
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      if (PM[idx] == 1) bits.push_back(^d);
      if (PM[idx] == 2) bits.push_back(~^d);
      for (int i = 0; i < NS[idx]; i++) bits.push_back(1'b1);
      for (int b = 0; b < bits.size(); b++)
         for (int c = 0; c < CPB; c++)
            exp_q.push_back('{bits[b], 1'b1, (b == bits.size() - 1) && (c == CPB - 1)});
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         cur = exp_q.pop_front();
         chk("frame_tx", 32'(tx_w[sel]), 32'(cur.tx));
         chk("frame_busy", 32'(busy_w[sel]), 32'(cur.busy));
         chk("frame_ready", 32'(ready_w[sel]), 32'(cur.ready));
      end
   end

   // Leaves valid high so a following send can chain back-to-back.
   task automatic send(input int idx, input logic [7:0] d);
      int n = 0;
      data = d;
      valid_w[idx] = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!ready_w[idx] && n < 300);
      chk("ready_timeout", 32'(ready_w[idx]), 32'd1);
      @(posedge clk);
      #1;
      push_frame(idx, d);
   endtask

   task automatic wait_drain(input int idx);
      int n = 0;
      while (exp_q.size() > 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      chk("idle_tx", 32'(tx_w[idx]), 32'd1);
      chk("idle_busy", 32'(busy_w[idx]), 32'd0);
      chk("idle_ready", 32'(ready_w[idx]), 32'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_tx", 32'(tx_w), 32'hF);
      chk("rst_busy", 32'(busy_w), 32'h0);
      chk("rst_ready", 32'(ready_w), 32'h0);
      rst_n = 1'b1;
      #1;
      chk("rel_ready_0", 32'(ready_w), 32'h0);
      @(negedge clk);
      chk("rel_ready_1", 32'(ready_w), 32'hF);

      sel = 0;
      send(0, 8'hA5);
      valid_w[0] = 1'b0;
      wait_drain(0);

      send(0, 8'h00);
      send(0, 8'hFF);
      valid_w[0] = 1'b0;
      wait_drain(0);

      sel = 1;
      send(1, 8'h07);
      valid_w[1] = 1'b0;
      wait_drain(1);

      sel = 2;
      send(2, 8'h07);
      valid_w[2] = 1'b0;
      wait_drain(2);

      sel = 3;
      send(3, 8'h3C);
      valid_w[3] = 1'b0;
      wait_drain(3);

      sel = 0;
      send(0, 8'h55);
      valid_w[0] = 1'b0;
      repeat (17) @(negedge clk);
      exp_q.delete();
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_tx", 32'(tx_w[0]), 32'd1);
      chk("midrst_busy", 32'(busy_w[0]), 32'd0);
      chk("midrst_ready", 32'(ready_w[0]), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("midrel_ready_0", 32'(ready_w[0]), 32'd0);
      @(negedge clk);
      chk("midrel_ready_1", 32'(ready_w[0]), 32'd1);
      chk("midrel_tx", 32'(tx_w[0]), 32'd1);
      send(0, 8'h81);
      valid_w[0] = 1'b0;
      wait_drain(0);

      send(0, 8'h3A);
      for (int i = 0; i < 35; i++) begin
         @(posedge clk);
         #1;
         valid_w[0] = 1'($urandom_range(0, 1));
         data = 8'($urandom);
      end
      valid_w[0] = 1'b0;
      wait_drain(0);
      repeat (8) @(negedge clk);
      chk("no_extra_busy", 32'(busy_w[0]), 32'd0);
      chk("no_extra_tx", 32'(tx_w[0]), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that drains a ready/valid byte stream and emits asynchronous serial frames (start, data LSB-first, optional parity, stop) on a single line. Sits directly downstream of `fifo`: its write port connects to the FIFO read port (`o_write_ready` → FIFO `i_read_ready`, FIFO `o_read_valid` → `i_write_valid`, FIFO `o_read_data` → `i_write_data`). The FIFO therefore absorbs bursts while this block paces them out at the bit rate.

## Interface
- `DATA_WIDTH`, 8: data bits per frame; must match the upstream FIFO `FIFO_REG_WIDTH`.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal values are ≥ 2.
- `PARITY_MODE`, 0: 0 = no parity, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2 stop bits.

- `i_clock`  in  1  Single clock; all state updates on the rising edge.
- `i_nreset`  in  1  Asynchronous, active-low reset.
- `o_write_ready`  out  1  Block can accept a word this cycle.
- `i_write_valid`  in  1  Upstream word valid.
- `i_write_data`  in  DATA_WIDTH  Word to transmit.
- `o_tx`  out  1  Serial line; idle-high.
- `o_busy`  out  1  A frame is in progress.

## Operation
- The block has one clock. Reset is asynchronous and active-low.
- All outputs are registered. While `i_nreset` is low:
  - `o_tx` = 1, `o_busy` = 0, `o_write_ready` = 0.
  - State = IDLE; counters = 0.
- `o_write_ready` rises on the first clock edge after reset release.
- A transfer occurs on a rising edge where `o_write_ready` & `i_write_valid` are both high.
  - `i_write_data` is latched into a shift register on that edge only.
  - `i_write_data` is ignored at all other times.
- FSM states and transitions:
  - IDLE → START on transfer.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA → PARITY after `DATA_WIDTH` bits, when `PARITY_MODE` ≠ 0.
  - DATA → STOP after `DATA_WIDTH` bits, when `PARITY_MODE` = 0.
  - PARITY → STOP after one bit.
  - STOP → IDLE after `STOP_BITS` bits.
  - STOP → START instead, if a transfer occurs in the final cycle of STOP.
- Line levels by state:
  - START: `o_tx` = 0.
  - DATA: `o_tx` = shift-register bit 0; shift right at the end of each bit period (LSB first).
  - PARITY: even mode sends XOR of the data word; odd mode sends its inverse.
  - STOP and IDLE: `o_tx` = 1.
- Counters:
  - Baud counter: width clog2(`CLKS_PER_BIT`), counts 0..`CLKS_PER_BIT`-1 and wraps at each bit boundary.
  - Bit counter: counts data bits, then stop bits; reset at every state change.
- `o_write_ready` is high in IDLE and in the last cycle of the last stop bit; low otherwise.
- `o_busy` = 1 in every state except IDLE. It stays 1 across back-to-back frames.
- Reset mid-frame: the line returns high asynchronously and the latched word is discarded. No frame resumes after release.
- `i_write_valid` asserted while `o_write_ready` is low has no effect. Upstream holds the word until ready, per FIFO rules.

## Timing
- Frame length F = 1 + `DATA_WIDTH` + (`PARITY_MODE` ≠ 0) + `STOP_BITS` bits, i.e. F × `CLKS_PER_BIT` cycles.
- Transfer on edge k gives:
  - `o_tx` = 0 in cycles k+1 .. k+`CLKS_PER_BIT`.
  - Data bit i in cycles k+1+(1+i)·`CLKS_PER_BIT` onward, each lasting `CLKS_PER_BIT` cycles.
- Latency from transfer edge to start-bit falling edge: 1 cycle.
- Back-to-back: a transfer in the final stop cycle makes the next start bit follow the stop bit with zero idle cycles. Sustained throughput is one word per F × `CLKS_PER_BIT` cycles.
- After reset release: `o_write_ready` = 1 one cycle later. The earliest start bit comes 2 cycles after release.

## Test plan
- `CLKS_PER_BIT`=4, no parity, 1 stop; send 0xA5 → `o_tx` = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total). `o_busy` is high for exactly 40 cycles; `o_write_ready` is high only in the last stop cycle.
- FIFO preloaded with 0x00 then 0xFF, `i_write_valid` held high → second start bit immediately follows the first stop bit. 80 cycles total, `o_busy` never drops, line = 0 ×36 cycles, then 1 ×4, 0 ×4, 1 ×36.
- `PARITY_MODE`=1, send 0x07 → parity bit 1. `PARITY_MODE`=2, send 0x07 → parity bit 0. Frame is 11 bits (44 cycles).
- `STOP_BITS`=2, send 0x3C → line high for 8 cycles after the last data bit before `o_write_ready` is seen high.
- Assert `i_nreset` low during data bit 3 of 0x55 → `o_tx`=1, `o_busy`=0, `o_write_ready`=0 immediately. After release, `o_write_ready`=1 one cycle later. A subsequent 0x81 frame is bit-exact with no residue of 0x55.
- Toggle `i_write_valid` and change `i_write_data` randomly mid-frame → no extra transfer, and the frame in progress is unchanged.
